sort_engine: RTL and testbench
==============================

SORT_ENGINE -- requirements
Module: sort_engine

Interface
REQ-001 Parameter DATA_WIDTH, default 8, width of one unsigned sample.
REQ-002 Parameter MAX_LENGTH, default 16, maximum packet length in samples (>=2).
REQ-003 Local constant LEN_WIDTH = clogb2(MAX_LENGTH), width of length and index counters.
REQ-004 src_clock  input  1  single clock; all logic is on its rising edge.
REQ-005 src_reset_n  input  1  reset, asynchronous assert, active-low.
REQ-006 snk_valid  input  1  input beat valid.
REQ-007 snk_sop  input  1  first beat of packet.
REQ-008 snk_eop  input  1  last beat of packet.
REQ-009 snk_data  input  DATA_WIDTH  input sample.
REQ-010 snk_ready  output  1  engine accepts a beat when snk_valid=1 and snk_ready=1.
REQ-011 src_valid  output  1  output beat valid.
REQ-012 src_sop  output  1  first sorted beat.
REQ-013 src_eop  output  1  last sorted beat.
REQ-014 src_data  output  DATA_WIDTH  sorted sample.
REQ-015 src_ready  input  1  downstream accepts a beat when src_valid=1 and src_ready=1.
REQ-016 err_overflow  output  1  one-cycle pulse when a packet exceeds MAX_LENGTH.

Function
REQ-017 FSM states IDLE, LOAD, SORT, OUT; reset state IDLE.
REQ-018 snk_ready=1 in IDLE and LOAD only; 0 in SORT and OUT.
REQ-019 IDLE: accepted beat without snk_sop is discarded; accepted beat with snk_sop is stored at index 0, length=1, go LOAD (or SORT if snk_eop is also 1).
REQ-020 LOAD: each accepted beat is stored at the next index and increments length; accepted beat with snk_eop -> SORT.
REQ-021 LOAD: accepted beat with snk_sop restarts the packet (index 0, length=1); previous partial data is dropped.
REQ-022 Beats beyond MAX_LENGTH are accepted and discarded; length saturates at MAX_LENGTH; err_overflow pulses once, on the cycle after the first discarded beat.
REQ-023 SORT: odd-even transposition; pass k (k=0..length-1) compare-exchanges pairs (i,i+1) with i even for even k, odd for odd k, only where i+1 < length; one pass per cycle; exactly length passes, then OUT.
REQ-024 Ordering is ascending unsigned; equal values are never swapped.
REQ-025 Latency: eop accepted at edge t -> SORT on cycles t+1..t+length -> src_valid=1 from cycle t+length+1.
REQ-026 OUT: emits buffer indices 0..length-1 in order; src_sop=1 on index 0, src_eop=1 on index length-1; both 1 for length 1.
REQ-027 src_valid, src_sop, src_eop, src_data are registered and held stable while src_valid=1 and src_ready=0.
REQ-028 Beat at index length-1 accepted -> IDLE next cycle; no back-to-back bubble-free overlap between packets is required.
REQ-029 src_sop/src_eop/src_data are 0 whenever src_valid=0.

Reset
REQ-030 src_reset_n=0 at any time, including mid-LOAD, mid-SORT or mid-OUT, aborts the packet: state IDLE, length 0, snk_ready=0 while asserted, src_valid=src_sop=src_eop=0, src_data=0, err_overflow=0.
REQ-031 Buffer contents need not be reset; after deassertion snk_ready=1 on the first clock edge.

Structure
REQ-032 Shared package sort_pkg holds clogb2, FSM state encoding and default DATA_WIDTH/MAX_LENGTH.
REQ-033 One sub-module sort_cas: combinational compare-exchange of two DATA_WIDTH values with enable, instantiated MAX_LENGTH-1 times.
REQ-034 Buffer is a register array (parallel access needed in SORT), not RAM.

Verification
REQ-035 Packet 5,3,9,1,7 (sop on 5, eop on 7), src_ready=1 -> output 1,3,5,7,9, sop on 1, eop on 9, first src_valid 6 cycles after eop edge.
REQ-036 Single beat 0x42 with sop=eop=1 -> one output beat 0x42 with sop=eop=1, 2 cycles after input.
REQ-037 18-beat packet 18 down to 1, MAX_LENGTH=16 -> err_overflow pulses once; output 3..18 (first 16 samples sorted), 16 beats.
REQ-038 Packet 4,4,0,255 with src_ready toggling 1,0,0,1,... -> output 0,4,4,255, each beat held unchanged while src_ready=0, no loss or duplication.
REQ-039 Beats 7,8 without sop, then sop 2, 1, sop 6, eop 5 -> 7,8 dropped, 2,1 dropped by restart; output 5,6.
REQ-040 Reset asserted in SORT of packet 3,2,1 -> all outputs 0 immediately; after release, packet 9,8 -> output 8,9 only.

Source files
------------

// File: rtl/sort_pkg.sv
// Shared definitions for the packet sort engine: default sizes, FSM
// state encoding and the width helper used for length/index counters.
package sort_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_MAX_LENGTH = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_SORT = 2'd2,
    ST_OUT  = 2'd3
  } state_t;

  // Number of bits needed to hold the value itself (not value-1), so a
  // length counter can reach MAX_LENGTH. Never returns less than 1.
  function automatic int clogb2(input int value);
    int w;
    w = 1;
    for (int i = 0; i < 31; i++) begin
      if ((value >> i) != 0) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/sort_if.sv
// Streaming bus of the sort engine: sink (input packet) side, source
// (sorted output) side, overflow pulse and a debug view of the FSM state.
//
// Handshake: a beat transfers on a rising edge where valid=1 and ready=1.
// The producer holds valid and its payload (sop/eop/data) unchanged until
// that transfer; ready may change freely and never depends on a transfer
// in the same cycle completing.
interface sort_if #(
  parameter int DATA_WIDTH = sort_pkg::DEF_DATA_WIDTH
) ();
  import sort_pkg::*;

  logic                  snk_valid;
  logic                  snk_sop;
  logic                  snk_eop;
  logic [DATA_WIDTH-1:0] snk_data;
  logic                  snk_ready;

  logic                  src_valid;
  logic                  src_sop;
  logic                  src_eop;
  logic [DATA_WIDTH-1:0] src_data;
  logic                  src_ready;

  logic                  err_overflow;
  state_t                dbg_state;

  // Engine side
  modport slave (
    input  snk_valid, snk_sop, snk_eop, snk_data, src_ready,
    output snk_ready, src_valid, src_sop, src_eop, src_data,
    output err_overflow, dbg_state
  );

  // Environment side (packet producer and sorted-data consumer)
  modport master (
    output snk_valid, snk_sop, snk_eop, snk_data, src_ready,
    input  snk_ready, src_valid, src_sop, src_eop, src_data,
    input  err_overflow, dbg_state
  );

endinterface

// File: rtl/sort_cas.sv
// Combinational compare-exchange cell: routes the smaller value to o_lo
// and the larger to o_hi when enabled. Equal values are left in place.
module sort_cas #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  i_en,
  input  logic [DATA_WIDTH-1:0] i_a,
  input  logic [DATA_WIDTH-1:0] i_b,
  output logic [DATA_WIDTH-1:0] o_lo,
  output logic [DATA_WIDTH-1:0] o_hi
);

  logic w_swap;

  // Swap only on strict greater-than so equal samples keep their order
  always_comb begin
    w_swap = i_en && (i_a > i_b);
    o_lo   = w_swap ? i_b : i_a;
    o_hi   = w_swap ? i_a : i_b;
  end

endmodule

// File: rtl/sort_engine.sv
// Packet sort engine: loads one packet into a register buffer, sorts it
// ascending with an odd-even transposition network (one pass per cycle),
// then streams it out with registered source outputs.
module sort_engine
  import sort_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int MAX_LENGTH = DEF_MAX_LENGTH
) (
  input  logic src_clock,
  input  logic src_reset_n,
  sort_if.slave bus
);

  localparam int LEN_WIDTH = clogb2(MAX_LENGTH);
  localparam logic [LEN_WIDTH-1:0] L_ONE = LEN_WIDTH'(1);
  localparam logic [LEN_WIDTH-1:0] L_MAX = LEN_WIDTH'(MAX_LENGTH);

  logic [DATA_WIDTH-1:0] r_buf  [MAX_LENGTH];
  logic [DATA_WIDTH-1:0] w_next [MAX_LENGTH];
  logic [DATA_WIDTH-1:0] w_lo   [MAX_LENGTH-1];
  logic [DATA_WIDTH-1:0] w_hi   [MAX_LENGTH-1];

  state_t                r_state, w_state_nxt;
  logic [LEN_WIDTH-1:0]  r_len, r_pass, r_out_idx, w_wr_idx;
  logic                  r_live, r_ovf_seen, r_err;
  logic                  r_src_valid, r_src_sop, r_src_eop;
  logic [DATA_WIDTH-1:0] r_src_data, w_out_data_nxt;
  logic                  w_snk_ready, w_snk_fire, w_src_fire;
  logic                  w_start, w_store, w_discard, w_sort_done, w_last_out;

  // r_live keeps snk_ready low while reset is held and for no longer
  assign w_snk_ready = r_live && (r_state == ST_IDLE || r_state == ST_LOAD);
  assign w_snk_fire  = bus.snk_valid && w_snk_ready;
  assign w_src_fire  = r_src_valid && bus.src_ready;
  assign w_start     = w_snk_fire && bus.snk_sop;
  assign w_store     = w_snk_fire && (w_start || (r_state == ST_LOAD && r_len < L_MAX));
  assign w_discard   = w_snk_fire && !bus.snk_sop && r_state == ST_LOAD && r_len == L_MAX;
  assign w_wr_idx    = w_start ? '0 : r_len;
  assign w_sort_done = (r_state == ST_SORT) && (r_pass == r_len - L_ONE);
  assign w_last_out  = (r_state == ST_OUT) && w_src_fire && (r_out_idx == r_len - L_ONE);

  assign bus.snk_ready    = w_snk_ready;
  assign bus.src_valid    = r_src_valid;
  assign bus.src_sop      = r_src_sop;
  assign bus.src_eop      = r_src_eop;
  assign bus.src_data     = r_src_data;
  assign bus.err_overflow = r_err;
  assign bus.dbg_state    = r_state;

  // Compare-exchange cells: pair (i,i+1) is active when i matches the pass
  // parity and both elements lie inside the packet
  for (genvar i = 0; i < MAX_LENGTH - 1; i++) begin : g_cas
    localparam logic PAR = 1'(i % 2);
    logic w_en;
    assign w_en = (PAR == r_pass[0]) && (LEN_WIDTH'(i + 1) < r_len);
    sort_cas #(.DATA_WIDTH(DATA_WIDTH)) u_cas (
      .i_en (w_en),
      .i_a  (r_buf[i]),
      .i_b  (r_buf[i+1]),
      .o_lo (w_lo[i]),
      .o_hi (w_hi[i])
    );
  end

  // Element j is the low side of pair j when its parity matches the pass,
  // otherwise the high side of pair j-1; edge elements may be unpaired
  for (genvar j = 0; j < MAX_LENGTH; j++) begin : g_next
    localparam logic PAR = 1'(j % 2);
    if (j == 0) begin : g_first
      assign w_next[j] = (PAR == r_pass[0]) ? w_lo[j] : r_buf[j];
    end else if (j == MAX_LENGTH - 1) begin : g_last
      assign w_next[j] = (PAR == r_pass[0]) ? r_buf[j] : w_hi[j-1];
    end else begin : g_mid
      assign w_next[j] = (PAR == r_pass[0]) ? w_lo[j] : w_hi[j-1];
    end
  end

  // Sample that follows the one currently presented on the source side
  always_comb begin
    w_out_data_nxt = '0;
    for (int j = 0; j < MAX_LENGTH; j++) begin
      if (r_out_idx + L_ONE == LEN_WIDTH'(j)) w_out_data_nxt = r_buf[j];
    end
  end

  // FSM state register
  always_ff @(posedge src_clock or negedge src_reset_n) begin
    if (!src_reset_n) r_state <= ST_IDLE;
    else              r_state <= w_state_nxt;
  end

  // FSM next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_start) w_state_nxt = bus.snk_eop ? ST_SORT : ST_LOAD;
      ST_LOAD: if (w_snk_fire && bus.snk_eop) w_state_nxt = ST_SORT;
      ST_SORT: if (w_sort_done) w_state_nxt = ST_OUT;
      ST_OUT:  if (w_last_out) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Sample buffer: written beat by beat while loading, in parallel while sorting
  always_ff @(posedge src_clock) begin
    if (r_state == ST_SORT) begin
      for (int j = 0; j < MAX_LENGTH; j++) r_buf[j] <= w_next[j];
    end else if (w_store) begin
      for (int j = 0; j < MAX_LENGTH; j++) begin
        if (w_wr_idx == LEN_WIDTH'(j)) r_buf[j] <= bus.snk_data;
      end
    end
  end

  // Length/pass/output counters, overflow pulse and registered source beat
  always_ff @(posedge src_clock or negedge src_reset_n) begin
    if (!src_reset_n) begin
      r_live      <= 1'b0;
      r_len       <= '0;
      r_pass      <= '0;
      r_out_idx   <= '0;
      r_ovf_seen  <= 1'b0;
      r_err       <= 1'b0;
      r_src_valid <= 1'b0;
      r_src_sop   <= 1'b0;
      r_src_eop   <= 1'b0;
      r_src_data  <= '0;
    end else begin
      r_live <= 1'b1;
      r_err  <= w_discard && !r_ovf_seen;
      if (w_start)        r_ovf_seen <= 1'b0;
      else if (w_discard) r_ovf_seen <= 1'b1;
      case (r_state)
        ST_IDLE, ST_LOAD: begin
          r_pass <= '0;
          if (w_start)      r_len <= L_ONE;
          else if (w_store) r_len <= r_len + L_ONE;
        end
        ST_SORT: begin
          r_pass <= r_pass + L_ONE;
          if (w_sort_done) begin
            r_src_valid <= 1'b1;
            r_src_sop   <= 1'b1;
            r_src_eop   <= (r_len == L_ONE);
            r_src_data  <= w_next[0];
            r_out_idx   <= '0;
          end
        end
        ST_OUT: begin
          if (w_last_out) begin
            r_src_valid <= 1'b0;
            r_src_sop   <= 1'b0;
            r_src_eop   <= 1'b0;
            r_src_data  <= '0;
            r_len       <= '0;
          end else if (w_src_fire) begin
            r_out_idx   <= r_out_idx + L_ONE;
            r_src_sop   <= 1'b0;
            r_src_eop   <= (r_out_idx + L_ONE == r_len - L_ONE);
            r_src_data  <= w_out_data_nxt;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sort_engine.sv
// Bench for sort_engine: drives packets on the sink side, models the
// expected sorted stream in a queue and checks the source side beat by beat.
module tb_sort_engine;
  import sort_pkg::*;

  localparam int DW     = 8;
  localparam int ML     = 16;
  localparam int PERIOD = 10;
  localparam int SAMPLE = PERIOD / 2 + 1;  // monitor samples at negedge + 1

  logic src_clock   = 1'b0;
  logic src_reset_n = 1'b0;

  sort_if #(.DATA_WIDTH(DW)) bus ();

  sort_engine #(.DATA_WIDTH(DW), .MAX_LENGTH(ML)) dut (
    .src_clock   (src_clock),
    .src_reset_n (src_reset_n),
    .bus         (bus.slave)
  );

  // ---------------- clock / reset ----------------
  always #(PERIOD / 2) src_clock = ~src_clock;

  // ---------------- scoreboard state ----------------
  int  n_checks = 0;
  int  n_errors = 0;
  logic [DW+1:0] exp_q[$];         // {sop, eop, data}
  logic [DW-1:0] m_buf[$];
  bit  m_active = 0;
  bit  m_ovf    = 0;
  int  exp_ovf  = 0;
  int  ovf_cnt  = 0;
  longint exp_ovf_time = 0;
  longint ovf_time     = 0;
  longint eop_time     = 0;
  longint first_valid_time = 0;
  int  ready_mode = 0;
  int  rcnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: sorts a copy of the accepted packet by insertion sort
  task automatic push_sorted();
    logic [DW-1:0] a[$];
    logic [DW-1:0] key;
    int j;
    a = m_buf;
    for (int i = 1; i < a.size(); i++) begin
      key = a[i];
      j = i - 1;
      while (j >= 0 && a[j] > key) begin
        a[j+1] = a[j];
        j--;
      end
      a[j+1] = key;
    end
    for (int i = 0; i < a.size(); i++)
      exp_q.push_back({1'(i == 0), 1'(i == a.size() - 1), a[i]});
  endtask

  // Reference model of the load rules for one accepted beat at edge time t
  task automatic model_beat(input bit sop, input bit eop, input logic [DW-1:0] d, input longint t);
    if (sop) begin
      m_buf.delete();
      m_buf.push_back(d);
      m_active = 1;
      m_ovf    = 0;
    end else if (m_active) begin
      if (m_buf.size() < ML) m_buf.push_back(d);
      else if (!m_ovf) begin
        m_ovf = 1;
        exp_ovf++;
        exp_ovf_time = t + SAMPLE;
      end
    end
    if (m_active && eop) begin
      push_sorted();
      m_active = 0;
      eop_time = t;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic send_beat(input bit sop, input bit eop, input logic [DW-1:0] d);
    bit done;
    done = 0;
    @(negedge src_clock);
    bus.snk_valid = 1'b1;
    bus.snk_sop   = sop;
    bus.snk_eop   = eop;
    bus.snk_data  = d;
    for (int k = 0; k < 500 && !done; k++) begin
      #1;
      if (bus.snk_ready) begin
        @(posedge src_clock);
        model_beat(sop, eop, d, $time);
        done = 1;
      end else begin
        @(negedge src_clock);
      end
    end
    check("snk_accept", 32'(done), 32'd1);
  endtask

  task automatic send_idle();
    @(negedge src_clock);
    bus.snk_valid = 1'b0;
    bus.snk_sop   = 1'b0;
    bus.snk_eop   = 1'b0;
    bus.snk_data  = '0;
  endtask

  task automatic send_pkt(input logic [DW-1:0] d[$]);
    for (int i = 0; i < d.size(); i++) send_beat(i == 0, i == d.size() - 1, d[i]);
    send_idle();
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 400 && exp_q.size() != 0; k++) @(negedge src_clock);
    check("drain", 32'(exp_q.size()), 32'd0);
    repeat (3) @(negedge src_clock);
  endtask

  // ---------------- downstream ready ----------------
  always @(negedge src_clock) begin
    case (ready_mode)
      0:       bus.src_ready = 1'b1;
      1:       bus.src_ready = (rcnt % 3 == 0);
      default: bus.src_ready = 1'($urandom_range(0, 1));
    endcase
    rcnt++;
  end

  // ---------------- monitor / scoreboard ----------------
  bit            prev_stall = 0;
  bit            prev_valid = 0;
  logic [DW+2:0] prev_beat  = '0;
  logic [DW+1:0] exp_beat;

  initial begin
    forever begin
      @(negedge src_clock);
      #1;
      if (prev_stall)
        check("hold", 32'({bus.src_valid, bus.src_sop, bus.src_eop, bus.src_data}), 32'(prev_beat));
      if (!bus.src_valid)
        check("idle_zero", 32'({bus.src_sop, bus.src_eop, bus.src_data}), 32'd0);
      if (bus.src_valid && !prev_valid) first_valid_time = $time;
      if (bus.src_valid && bus.src_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", 32'(exp_q.size()), 32'd1);
        end else begin
          exp_beat = exp_q.pop_front();
          check("out_beat", 32'({bus.src_sop, bus.src_eop, bus.src_data}), 32'(exp_beat));
        end
      end
      if (bus.err_overflow) begin
        ovf_cnt++;
        ovf_time = $time;
      end
      prev_stall = bus.src_valid && !bus.src_ready;
      prev_beat  = {bus.src_valid, bus.src_sop, bus.src_eop, bus.src_data};
      prev_valid = bus.src_valid;
    end
  end

  // ---------------- test sequence ----------------
  logic [DW-1:0] pkt[$];
  int            len;

  initial begin
    bus.snk_valid = 1'b0;
    bus.snk_sop   = 1'b0;
    bus.snk_eop   = 1'b0;
    bus.snk_data  = '0;
    bus.src_ready = 1'b1;

    // Reset state
    #3;
    check("rst_snk_ready", 32'(bus.snk_ready), 32'd0);
    check("rst_src", 32'({bus.src_valid, bus.src_sop, bus.src_eop, bus.src_data, bus.err_overflow}), 32'd0);
    check("rst_state", 32'(bus.dbg_state), 32'(ST_IDLE));
    repeat (3) @(negedge src_clock);
    src_reset_n = 1'b1;
    @(posedge src_clock);
    #1;
    check("post_rst_ready", 32'(bus.snk_ready), 32'd1);

    // Basic five-sample packet with latency
    pkt = '{8'd5, 8'd3, 8'd9, 8'd1, 8'd7};
    send_pkt(pkt);
    wait_drain();
    check("lat_len5", 32'(first_valid_time - eop_time), 32'(5 * PERIOD + SAMPLE));

    // Single beat with sop and eop together
    pkt = '{8'h42};
    send_pkt(pkt);
    wait_drain();
    check("lat_len1", 32'(first_valid_time - eop_time), 32'(1 * PERIOD + SAMPLE));
    check("ovf_none", 32'(ovf_cnt), 32'd0);

    // Overflow: 18 beats counting down, only the first 16 survive
    pkt.delete();
    for (int v = 18; v >= 1; v--) pkt.push_back(8'(v));
    send_pkt(pkt);
    wait_drain();
    check("ovf_count", 32'(ovf_cnt), 32'(exp_ovf));
    check("ovf_time", 32'(ovf_time), 32'(exp_ovf_time));
    check("ovf_len16", 32'(first_valid_time - eop_time), 32'(16 * PERIOD + SAMPLE));

    // Back-pressure with duplicates and extremes
    rcnt = 0;
    ready_mode = 1;
    pkt = '{8'd4, 8'd4, 8'd0, 8'd255};
    send_pkt(pkt);
    wait_drain();
    ready_mode = 0;

    // Beats without sop are dropped; sop inside a packet restarts it
    send_beat(0, 0, 8'd7);
    send_beat(0, 0, 8'd8);
    send_beat(1, 0, 8'd2);
    send_beat(0, 0, 8'd1);
    send_beat(1, 0, 8'd6);
    send_beat(0, 1, 8'd5);
    send_idle();
    wait_drain();

    // Random packets, including some overlong ones, with random back-pressure
    ready_mode = 2;
    for (int p = 0; p < 8; p++) begin
      len = $urandom_range(1, ML + 2);
      pkt.delete();
      for (int i = 0; i < len; i++) pkt.push_back(8'($urandom_range(0, 255)));
      send_pkt(pkt);
      wait_drain();
    end
    ready_mode = 0;
    check("ovf_count_rand", 32'(ovf_cnt), 32'(exp_ovf));

    // Reset during SORT aborts the packet
    pkt = '{8'd3, 8'd2, 8'd1};
    send_pkt(pkt);
    check("in_sort", 32'(bus.dbg_state), 32'(ST_SORT));
    src_reset_n = 1'b0;
    exp_q.delete();
    m_active = 0;
    #1;
    check("mid_rst_src", 32'({bus.src_valid, bus.src_sop, bus.src_eop, bus.src_data, bus.err_overflow}), 32'd0);
    check("mid_rst_ready", 32'(bus.snk_ready), 32'd0);
    check("mid_rst_state", 32'(bus.dbg_state), 32'(ST_IDLE));
    repeat (2) @(negedge src_clock);
    check("mid_rst_hold", 32'({bus.src_valid, bus.snk_ready}), 32'd0);
    src_reset_n = 1'b1;
    @(posedge src_clock);
    #1;
    check("rel_ready", 32'(bus.snk_ready), 32'd1);
    pkt = '{8'd9, 8'd8};
    send_pkt(pkt);
    wait_drain();
    check("lat_len2", 32'(first_valid_time - eop_time), 32'(2 * PERIOD + SAMPLE));
    check("ovf_final", 32'(ovf_cnt), 32'(exp_ovf));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
